// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM state, requester-id width helper
// and the one-deep read response pipe entry.
package ram_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Wide enough for the largest supported requester count (8).
   localparam int MAX_ID_W = 3;

   function automatic int req_id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } rsp_pipe_t;

endpackage

// File: rtl/ram_port_arbiter_picker.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr,
// wrapping, found by masking a doubled request vector.
module rr_priority_picker
   import ram_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = req_id_w(N)
) (
   input  logic [N-1:0]    valid,
   input  logic [ID_W-1:0] rr_ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_idx
);

   logic [2*N-1:0] masked;
   logic           found;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      gnt_idx = '0;
      found   = 1'b0;
      // The upper copy is fully unmasked, so requesters below rr_ptr are seen after the wrap.
      masked  = {valid, valid} & ({(2*N){1'b1}} << rr_ptr);
      for (int k = 0; k < 2*N; k++) begin
         if (!found && masked[k]) begin
            found   = 1'b1;
            gnt_idx = ID_W'(k % N);
         end
      end
      gnt = found ? (N'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with burst
// locking, a MAX_BURST cap and routing of the 1-cycle read data to its issuer.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_BURST  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          ram_en,
   output logic                          ram_we,
   output logic [ADDR_WIDTH-1:0]         ram_addr,
   output logic [DATA_WIDTH-1:0]         ram_din,
   input  logic [DATA_WIDTH-1:0]         ram_dout,
   output logic                          busy
);

   localparam int ID_W  = req_id_w(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e       state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   rsp_pipe_t        rsp_q, rsp_d;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic [ID_W-1:0]       pick_idx;
   logic [NUM_REQ-1:0]    grant;
   logic [ID_W-1:0]       sel;
   logic                  accept;
   logic                  sel_we;
   logic                  sel_last;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] x);
      return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
   endfunction

   rr_priority_picker #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_picker (
      .valid   (req_valid),
      .rr_ptr  (rr_ptr_q),
      .gnt     (pick_gnt),
      .gnt_idx (pick_idx)
   );

   always_comb begin
      if (state_q == LOCKED) begin
         sel   = owner_q;
         grant = req_valid & (NUM_REQ'(1) << owner_q);
      end else begin
         sel   = pick_idx;
         grant = pick_gnt;
      end
      // NOTE: ready is qualified by rst_n so nothing is granted while reset is held.
      req_ready = grant & {NUM_REQ{rst_n}};
      accept    = |req_ready;

      sel_we    = 1'b0;
      sel_last  = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == sel) begin
            sel_we    = req_we[i];
            sel_last  = req_last[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      ram_en   = accept;
      ram_we   = accept & sel_we;
      ram_addr = accept ? sel_addr  : '0;
      ram_din  = accept ? sel_wdata : '0;
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      rsp_d.valid = accept & ~sel_we;
      rsp_d.id    = MAX_ID_W'(sel);

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!sel_last && (MAX_BURST > 1)) begin
                  state_d    = LOCKED;
                  owner_d    = sel;
                  beat_cnt_d = CNT_W'(1);
               end else begin
                  rr_ptr_d = wrap_inc(sel);
               end
            end
         end
         LOCKED: begin
            // Owner dropping valid releases the lock just like a last or capped beat.
            if (!accept || sel_last || (beat_cnt_q == CNT_W'(MAX_BURST - 1))) begin
               state_d    = IDLE;
               rr_ptr_d   = wrap_inc(owner_q);
               beat_cnt_d = '0;
            end else begin
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         rsp_q      <= rsp_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_valid[i] = rsp_q.valid && (rsp_q.id == MAX_ID_W'(i));
      end
      rsp_rdata = ram_dout;
      busy      = (state_q == LOCKED) || rsp_q.valid;
   end

endmodule
